// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ADD   = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Counter must hold the value WIDTH itself, so it needs one bit beyond $clog2.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage : mult_pkg

// File: rtl/mult_datapath.sv
// Accumulator A, multiplicand M, multiplier Q, the A+M adder and the product register.
module mult_datapath #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_capture,
   input  logic               i_load,
   input  logic               i_add,
   input  logic               i_shift,
   input  logic               i_last,
   input  logic [WIDTH-1:0]   i_multiplicand,
   input  logic [WIDTH-1:0]   i_multiplier,
   output logic               o_q_lsb,
   output logic [2*WIDTH-1:0] o_product
);

   logic [WIDTH:0]     r_a;
   logic [WIDTH-1:0]   r_m;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_hold_m;
   logic [WIDTH-1:0]   r_hold_q;
   logic [2*WIDTH-1:0] r_product;

   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH:0]   w_shifted;

   // A keeps its carry bit, so A + M never overflows before the shift.
   assign w_sum     = r_a + {1'b0, r_m};
   assign w_shifted = {1'b0, r_a, r_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_a       <= '0;
         r_m       <= '0;
         r_q       <= '0;
         r_hold_m  <= '0;
         r_hold_q  <= '0;
         r_product <= '0;
      end else begin
         // Operands are frozen at go acceptance so later input changes are harmless.
         if (i_capture) begin
            r_hold_m <= i_multiplicand;
            r_hold_q <= i_multiplier;
         end
         if (i_load) begin
            r_a       <= '0;
            r_m       <= r_hold_m;
            r_q       <= r_hold_q;
            r_product <= '0;
         end else if (i_add) begin
            r_a <= w_sum;
         end else if (i_shift) begin
            r_a <= w_shifted[2*WIDTH:WIDTH];
            r_q <= w_shifted[WIDTH-1:0];
            if (i_last) begin
               r_product <= w_shifted[2*WIDTH-1:0];
            end
         end
      end
   end

   assign o_q_lsb   = r_q[0];
   assign o_product = r_product;

endmodule : mult_datapath

// File: rtl/multiplication_fsm.sv
// Control FSM and bit counter for a WIDTH x WIDTH unsigned shift-and-add multiplier.
module multiplication_fsm
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               load,
   output logic               add,
   output logic               shift,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   state_t        r_state;
   state_t        w_next_state;
   logic [CW-1:0] r_count;

   logic w_capture;
   logic w_load;
   logic w_add;
   logic w_shift;
   logic w_busy;
   logic w_done;
   logic w_last;
   logic w_q_lsb;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_load) begin
            r_count <= '0;
         end else if (w_shift) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // NOTE: every output gets a default first so no path through the case can infer a latch.
   always_comb begin
      w_next_state = S_IDLE;
      w_capture    = 1'b0;
      w_load       = 1'b0;
      w_add        = 1'b0;
      w_shift      = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_capture    = go;
            w_next_state = go ? S_LOAD : S_IDLE;
         end
         S_LOAD: begin
            w_load       = 1'b1;
            w_busy       = 1'b1;
            w_next_state = S_ADD;
         end
         S_ADD: begin
            w_add        = w_q_lsb;
            w_busy       = 1'b1;
            w_next_state = S_SHIFT;
         end
         S_SHIFT: begin
            w_shift      = 1'b1;
            w_busy       = 1'b1;
            w_next_state = (r_count == LAST_CNT) ? S_DONE : S_ADD;
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
      // Reset silences every strobe immediately, even before the first edge lands.
      if (!reset) begin
         w_capture = 1'b0;
         w_load    = 1'b0;
         w_add     = 1'b0;
         w_shift   = 1'b0;
         w_busy    = 1'b0;
         w_done    = 1'b0;
      end
   end

   assign w_last = (r_count == LAST_CNT);

   mult_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk           (clk),
      .reset         (reset),
      .i_capture     (w_capture),
      .i_load        (w_load),
      .i_add         (w_add),
      .i_shift       (w_shift),
      .i_last        (w_last),
      .i_multiplicand(multiplicand),
      .i_multiplier  (multiplier),
      .o_q_lsb       (w_q_lsb),
      .o_product     (product)
   );

   assign load  = w_load;
   assign add   = w_add;
   assign shift = w_shift;
   assign busy  = w_busy;
   assign done  = w_done;

endmodule : multiplication_fsm

// File: doc/multiplication_fsm.md
MULTIPLICATION_FSM -- requirements
Module: multiplication_fsm

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand width; the product width SHALL be 2*WIDTH.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  SHALL be the reset; synchronous and active-low (asserted when 0, sampled on rising clk).
REQ-004 go  input  1  SHALL be the start request, sampled only in S_IDLE.
REQ-005 multiplicand  input  WIDTH  SHALL be the multiplicand operand, captured on go acceptance.
REQ-006 multiplier  input  WIDTH  SHALL be the multiplier operand, captured on go acceptance.
REQ-007 load  output  1  SHALL be the operand-load strobe, high in S_LOAD only.
REQ-008 add  output  1  SHALL be the conditional-add strobe, high in S_ADD only when the multiplier-register LSB is 1.
REQ-009 shift  output  1  SHALL be the right-shift strobe, high in S_SHIFT only.
REQ-010 busy  output  1  SHALL be high in every state except S_IDLE and S_DONE.
REQ-011 done  output  1  SHALL be the completion pulse, high for exactly one cycle in S_DONE.
REQ-012 product  output  2*WIDTH  SHALL be the unsigned product, valid from S_DONE and held until the next accepted go.

Function
REQ-013 States SHALL be S_IDLE, S_LOAD, S_ADD, S_SHIFT, S_DONE.
REQ-014 S_IDLE SHALL go to S_LOAD when go=1; otherwise it SHALL stay in S_IDLE.
REQ-015 S_LOAD SHALL clear accumulator A (WIDTH+1 bits, carry included), load register M with multiplicand, load register Q with multiplier, clear the bit counter, and then go to S_ADD.
REQ-016 S_ADD SHALL set A = A + M (zero-extended) when Q[0]=1, leave A unchanged otherwise, and then go to S_SHIFT.
REQ-017 S_SHIFT SHALL logically right-shift the concatenation {A,Q} by one bit with 0 shifted into the A MSB, increment the counter, and then go to S_DONE if the counter reaches WIDTH, or back to S_ADD otherwise.
REQ-018 S_DONE SHALL assert done, drive product = {A[WIDTH-1:0],Q}, and then go to S_IDLE unconditionally.
REQ-019 Latency SHALL be fixed at 2*WIDTH+2 cycles from the edge that samples go to the edge that leaves S_DONE; for WIDTH=4, done SHALL be high in cycle 10 after go (counting the go-sampling cycle as cycle 0).
REQ-020 go SHALL be ignored in every state except S_IDLE; operand changes while busy=1 SHALL NOT affect the result.
REQ-021 If go=1 in S_DONE, it SHALL be ignored; a go held high SHALL be accepted in the following S_IDLE cycle, giving back-to-back operation with one idle cycle.
REQ-022 The product register SHALL hold its value through S_IDLE until the next S_LOAD clears it.
REQ-023 Arithmetic SHALL be unsigned and SHALL NOT overflow: max (2^WIDTH-1)^2 fits in 2*WIDTH bits, and A carry is kept in A[WIDTH] before the shift.
REQ-024 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within one operation.
REQ-025 Any illegal state encoding SHALL return to S_IDLE on the next edge.

Reset
REQ-026 When reset=0 at a rising clk, the state SHALL become S_IDLE, and A, M, Q, counter and product SHALL become 0.
REQ-027 During and after reset, load, add, shift, busy and done SHALL be 0.
REQ-028 Reset mid-operation SHALL abort immediately with no done pulse; the next go after reset release SHALL start a clean operation.

Structure
REQ-029 Package mult_pkg SHALL hold the state_t enum and the default WIDTH constant.
REQ-030 The control FSM and counter SHALL live in multiplication_fsm.
REQ-031 A, M, Q and the adder SHALL be in one sub-module, mult_datapath, driven by load/add/shift.

Verification
REQ-032 Reset held low for 3 cycles with go=1 -> all outputs 0, state S_IDLE, no done pulse.
REQ-033 multiplicand=13, multiplier=11, go for 1 cycle -> done in cycle 10, product=143 (0x8F), add pulsed 3 times, shift pulsed 4 times.
REQ-034 15x15 -> product=225 (0xE1); 0x9 -> product=0 with add never asserted; 1x1 -> product=1.
REQ-035 go toggled and operands changed while busy=1 -> result unchanged, exactly one done pulse.
REQ-036 reset=0 asserted in the third S_ADD cycle of 7x6 -> no done pulse; a following 7x6 -> product=42 with correct latency.
REQ-037 go held high across two operations (3x5 then 2x4) -> done pulses 11 cycles apart, products 15 then 8.
